// File: rtl/pool_pkg.sv
// Shared types and the window-average helper for the 2x2 average-pooling stream.
// Build option AVG_POOL_ROUND_EN selects round-half-up instead of floor in avg4.
package pool_pkg;

  localparam int DATA_W = 32;

  typedef logic signed [DATA_W-1:0] data_t;
  typedef logic signed [DATA_W:0]   pair_t;
  typedef logic signed [DATA_W+1:0] sum_t;

  // A 4-sample mean of DATA_W values always fits back into DATA_W bits.
  function automatic data_t avg4(input sum_t s);
    sum_t q;
`ifdef AVG_POOL_ROUND_EN
    q = (s + sum_t'(2)) >>> 2;
`else
    q = s >>> 2;
`endif
    return data_t'(q[DATA_W-1:0]);
  endfunction

endpackage

// File: rtl/avg_pool_stream_if.sv
// Valid/ready sample stream used on both sides of the pooling stage.
// 'last' marks the final beat of a frame and is only meaningful on the output side.
interface avg_pool_stream_if;
  import pool_pkg::*;

  data_t data;
  logic  valid;
  logic  ready;
  logic  last;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);

endinterface

// File: rtl/pool_line_buf.sv
// One row of horizontal pair sums, written on even rows and read back on odd rows.
// Storage is deliberately unreset: every entry is rewritten before it is consumed.
module pool_line_buf #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     idx,
  input  pool_pkg::pair_t   wdata,
  output pool_pkg::pair_t   rdata
);
  import pool_pkg::*;

  pair_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[idx] <= wdata;
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/avg_pool_stream.sv
// Streaming 2x2 average pooling: raster-order WIDTH_IN^2 map in, WIDTH_OUT^2 window means out.
// Rounding mode follows AVG_POOL_ROUND_EN (see pool_pkg::avg4); timing is identical either way.
module avg_pool_stream #(
  parameter int WIDTH_IN = 8,
  parameter int DATA_W   = pool_pkg::DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_clr,
  avg_pool_stream_if.slave      in_if,
  avg_pool_stream_if.master     out_if
);
  import pool_pkg::*;

  localparam int WIDTH_OUT = WIDTH_IN / 2;
  localparam int CW = (WIDTH_IN > 2) ? $clog2(WIDTH_IN) : 1;
  localparam int AW = (WIDTH_OUT > 1) ? $clog2(WIDTH_OUT) : 1;

  if (WIDTH_IN < 2 || (WIDTH_IN % 2) != 0) begin : g_bad_width
    $error("avg_pool_stream: WIDTH_IN must be even and >= 2");
  end
  if (DATA_W != pool_pkg::DATA_W) begin : g_bad_data_w
    $error("avg_pool_stream: DATA_W must match pool_pkg::DATA_W");
  end

  logic [CW-1:0] col_q, col_d, row_q, row_d;
  data_t         h_reg_q, h_reg_d;
  data_t         out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;

  logic          in_ready, accept, lb_we, load, col_last, row_last;
  logic [AW-1:0] lb_idx;
  pair_t         pair, lb_rdata;
  sum_t          sum;

  assign in_ready = !out_valid_q || out_if.ready;
  assign accept   = in_if.valid && in_ready && !frame_clr;
  assign col_last = (col_q == CW'(WIDTH_IN - 1));
  assign row_last = (row_q == CW'(WIDTH_IN - 1));
  assign lb_idx   = AW'(col_q >> 1);

  pool_line_buf #(.DEPTH(WIDTH_OUT), .AW(AW)) u_line_buf (
    .clk   (clk),
    .we    (lb_we),
    .idx   (lb_idx),
    .wdata (pair),
    .rdata (lb_rdata)
  );

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    h_reg_d     = h_reg_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    lb_we       = 1'b0;
    load        = 1'b0;
    pair        = pair_t'(h_reg_q) + pair_t'(in_if.data);
    sum         = sum_t'(lb_rdata) + sum_t'(pair);

    if (frame_clr) begin
      col_d   = '0;
      row_d   = '0;
      h_reg_d = '0;
    end else if (accept) begin
      if (!col_q[0])      h_reg_d = in_if.data;
      else if (!row_q[0]) lb_we   = 1'b1;
      else                load    = 1'b1;

      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + CW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end

    // A new window result may replace the one being popped in the same cycle.
    if (load) begin
      out_data_d  = avg4(sum);
      out_valid_d = 1'b1;
      out_last_d  = col_last && row_last;
    end else if (out_valid_q && out_if.ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      h_reg_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      h_reg_q     <= h_reg_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign in_if.ready  = in_ready;
  assign out_if.data  = out_data_q;
  assign out_if.valid = out_valid_q;
  assign out_if.last  = out_last_q;

endmodule

// File: tb/tb_avg_pool_stream.sv
// Bench for avg_pool_stream (WIDTH_IN=4): directed scenarios plus random traffic
// checked against a whole-frame reference model; honours AVG_POOL_ROUND_EN.
module tb_avg_pool_stream;
  import pool_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic frame_clr = 1'b0;

  always #5 clk = ~clk;

  avg_pool_stream_if in_if ();
  avg_pool_stream_if out_if ();

  avg_pool_stream #(.WIDTH_IN(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame_clr (frame_clr),
    .in_if     (in_if.slave),
    .out_if    (out_if.master)
  );

  typedef struct {
    logic [31:0] d;
    logic        l;
  } exp_t;

  int          vectors = 0;
  int          miscompares = 0;
  exp_t        expq[$];
  logic [31:0] popped[$];
  longint      img[N][N];
  int          pos = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic longint floor_div4(input longint s);
    longint q;
    q = s / 4;
    if ((s % 4) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  function automatic logic [31:0] ref_avg(input longint s);
`ifdef AVG_POOL_ROUND_EN
    return 32'(floor_div4(s + 2));
`else
    return 32'(floor_div4(s));
`endif
  endfunction

  task automatic model_accept(input logic [31:0] d);
    int r, c;
    longint s;
    exp_t e;
    r = pos / N;
    c = pos % N;
    img[r][c] = longint'($signed(d));
    if ((r % 2) == 1 && (c % 2) == 1) begin
      s = img[r-1][c-1] + img[r-1][c] + img[r][c-1] + img[r][c];
      e.d = ref_avg(s);
      e.l = (pos == N*N - 1);
      expq.push_back(e);
    end
    pos = (pos + 1) % (N*N);
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic ordy,
                      input logic clr, output logic acc);
    exp_t e;
    @(negedge clk);
    in_if.valid  = v;
    in_if.data   = d;
    out_if.ready = ordy;
    frame_clr    = clr;
    #1;
    if (out_if.valid && ordy) begin
      popped.push_back(out_if.data);
      if (expq.size() == 0) begin
        chk("spurious_out", 32'(out_if.valid), 32'(0));
      end else begin
        e = expq.pop_front();
        chk("out_data", out_if.data, e.d);
        chk("out_last", 32'(out_if.last), 32'(e.l));
      end
    end
    acc = v && in_if.ready && !clr;
    if (acc) model_accept(d);
    if (clr) pos = 0;
  endtask

  task automatic send(input logic [31:0] d, input bit rnd_ready);
    logic acc;
    int   n;
    n = 0;
    do begin
      step(1'b1, d, rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1, 1'b0, acc);
      n++;
    end while (!acc && n < 64);
    if (!acc) chk("send_timeout", 32'(0), 32'(1));
  endtask

  task automatic send_ramp(input int first, input int count);
    for (int i = 0; i < count; i++) send(32'(first + i), 1'b0);
  endtask

  task automatic drain();
    logic acc;
    repeat (8) step(1'b0, 32'h0, 1'b1, 1'b0, acc);
    chk("drain_left", 32'(expq.size()), 32'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    in_if.valid  = 1'b0;
    out_if.ready = 1'b1;
    frame_clr    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expq.delete();
    popped.delete();
    pos = 0;
  endtask

  task automatic check_ramp_outputs(input string tag);
    logic [31:0] ref_vals[4];
`ifdef AVG_POOL_ROUND_EN
    ref_vals = '{32'd3, 32'd5, 32'd11, 32'd13};
`else
    ref_vals = '{32'd2, 32'd4, 32'd10, 32'd12};
`endif
    chk({tag, "_count"}, 32'(popped.size()), 32'(4));
    for (int i = 0; i < 4 && i < popped.size(); i++) chk(tag, popped[i], ref_vals[i]);
    popped.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc;
    int          cnt;
    logic [31:0] d;

    in_if.valid  = 1'b0;
    in_if.data   = '0;
    in_if.last   = 1'b0;
    out_if.ready = 1'b1;

    do_reset();
    #1;
    chk("rst_out_valid", 32'(out_if.valid), 32'(0));
    chk("rst_out_last", 32'(out_if.last), 32'(0));
    chk("rst_out_data", out_if.data, 32'(0));
    chk("rst_in_ready", 32'(in_if.ready), 32'(1));

    // Ramp frame 0..15.
    send_ramp(0, 16);
    drain();
    check_ramp_outputs("ramp");

    // Uniform -3 frame.
    for (int i = 0; i < 16; i++) send(32'hFFFF_FFFD, 1'b0);
    drain();
    chk("neg3", popped[0], 32'hFFFF_FFFD);
    popped.delete();

    // Window -1,0,0,0.
    for (int i = 0; i < 16; i++) send((i == 0) ? 32'hFFFF_FFFF : 32'h0, 1'b0);
    drain();
`ifdef AVG_POOL_ROUND_EN
    chk("neg1_win", popped[0], 32'h0);
`else
    chk("neg1_win", popped[0], 32'hFFFF_FFFF);
`endif
    popped.delete();

    // Backpressure: output held while the next samples are offered.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 32'(i), 1'b0, 1'b0, acc);
      chk("bp_pre_acc", 32'(acc), 32'(1));
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 32'd6, 1'b0, 1'b0, acc);
      chk("bp_in_ready", 32'(in_if.ready), 32'(0));
      chk("bp_out_valid", 32'(out_if.valid), 32'(1));
    end
    send_ramp(6, 10);
    drain();
    check_ramp_outputs("bp");

    // Saturation extremes.
    for (int i = 0; i < 16; i++) send(32'h7FFF_FFFF, 1'b0);
    drain();
    for (int i = 0; i < 4; i++) chk("max_pos", popped[i], 32'h7FFF_FFFF);
    popped.delete();
    for (int i = 0; i < 16; i++) send(32'h8000_0000, 1'b0);
    drain();
    for (int i = 0; i < 4; i++) chk("max_neg", popped[i], 32'h8000_0000);
    popped.delete();

    // Reset mid-frame drops partial state and the pending output.
    send_ramp(0, 6);
    do_reset();
    send_ramp(0, 16);
    drain();
    check_ramp_outputs("midrst");

    // frame_clr with a coincident valid sample.
    send_ramp(0, 3);
    step(1'b1, 32'd3, 1'b1, 1'b1, acc);
    chk("clr_drop", 32'(acc), 32'(0));
    send_ramp(0, 16);
    drain();
    check_ramp_outputs("fclr");

    // Two back-to-back frames with no bubble.
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 32'(i % 16), 1'b1, 1'b0, acc);
      if (acc) cnt++;
    end
    chk("b2b_accepts", 32'(cnt), 32'(32));
    drain();
    chk("b2b_outputs", 32'(popped.size()), 32'(8));
    popped.delete();

    // Random traffic with gaps, backpressure and mixed-magnitude data.
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 16; i++) begin
        while ($urandom_range(0, 3) == 0) step(1'b0, $urandom, ($urandom_range(0, 1) == 1), 1'b0, acc);
        case ($urandom_range(0, 3))
          0:       d = 32'h7FFF_FFFF - 32'($urandom_range(0, 3));
          1:       d = 32'h8000_0000 + 32'($urandom_range(0, 3));
          2:       d = 32'($signed($urandom_range(0, 15)) - 8);
          default: d = $urandom;
        endcase
        send(d, 1'b1);
      end
    end
    drain();
    chk("rand_outputs", 32'(popped.size()), 32'(24));
    popped.delete();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
